// File: rtl/cw305_reg_initiator_pkg.sv
// Shared types and constants for the CW305 register-bus initiator.
package cw305_reg_initiator_pkg;

  localparam int ADDR_WIDTH_DEFAULT   = 21;
  localparam int BYTECNT_SIZE_DEFAULT = 7;
  localparam int READ_LATENCY_DEFAULT = 1;

  // Register address field width: full bus address minus the byte-count bits.
  localparam int REG_ADDR_WIDTH = ADDR_WIDTH_DEFAULT - BYTECNT_SIZE_DEFAULT;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_STROBE,
    S_RD_STROBE,
    S_RD_WAIT,
    S_RD_HOLD
  } state_t;

endpackage

// File: rtl/cw305_reg_initiator.sv
// Master side of the CW305 register bus: turns one command (address, length,
// direction) into a burst of per-byte strobes with an incrementing byte index.
// Write bytes arrive on a valid/ready stream, read bytes leave on another.
module cw305_reg_initiator
  import cw305_reg_initiator_pkg::*;
#(
  parameter int pADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter int pBYTECNT_SIZE = BYTECNT_SIZE_DEFAULT,
  parameter int pREAD_LATENCY = READ_LATENCY_DEFAULT
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_n,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_write,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_addr,
  input  logic [pBYTECNT_SIZE:0]               cmd_len,
  input  logic                                 wdata_valid,
  output logic                                 wdata_ready,
  input  logic [7:0]                           wdata,
  output logic                                 rdata_valid,
  input  logic                                 rdata_ready,
  output logic [7:0]                           rdata,
  output logic                                 rdata_last,
  output logic                                 busy,
  output logic                                 done,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           write_data,
  input  logic [7:0]                           read_data,
  output logic                                 reg_read,
  output logic                                 reg_write,
  output logic                                 reg_addrvalid
);

  localparam int         AW       = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int         BW       = pBYTECNT_SIZE;
  localparam logic [1:0] LAT_INIT = 2'(pREAD_LATENCY);
  localparam logic [BW:0] CNT_ONE = {{BW{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  // Length and byte counter carry one extra bit so a full 2^BW burst fits.
  logic [BW:0]     len_q, len_d;
  logic [BW:0]     cnt_q, cnt_d, cnt_inc;
  logic [1:0]      lat_q, lat_d;
  logic            is_last;
  logic            done_d;
  logic [7:0]      rdata_d, write_data_d;
  logic [AW-1:0]   reg_address_d;
  logic [BW-1:0]   reg_bytecnt_d;

  // Handshake readies decode the state register only, never an input.
  assign cmd_ready   = (state_q == S_IDLE);
  assign wdata_ready = (state_q == S_WR_DATA);
  assign cnt_inc     = cnt_q + CNT_ONE;
  assign is_last     = (cnt_q == len_q - CNT_ONE);

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    rdata_d       = rdata;
    write_data_d  = write_data;
    reg_address_d = reg_address;
    reg_bytecnt_d = reg_bytecnt;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (cmd_write == CMD_WRITE) begin
            state_d = S_WR_DATA;
          end else begin
            reg_address_d = cmd_addr;
            reg_bytecnt_d = '0;
            state_d       = S_RD_STROBE;
          end
        end
      end

      S_WR_DATA: begin
        if (wdata_valid) begin
          write_data_d  = wdata;
          reg_address_d = addr_q;
          reg_bytecnt_d = cnt_q[BW-1:0];
          state_d       = S_WR_STROBE;
        end
      end

      S_WR_STROBE: begin
        if (is_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_inc;
          state_d = S_WR_DATA;
        end
      end

      S_RD_STROBE: begin
        lat_d   = LAT_INIT;
        state_d = S_RD_WAIT;
      end

      // Capture happens at the end of the cycle pREAD_LATENCY after the strobe.
      S_RD_WAIT: begin
        if (lat_q == 2'd1) begin
          rdata_d = read_data;
          state_d = S_RD_HOLD;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      S_RD_HOLD: begin
        if (rdata_ready) begin
          if (is_last) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d         = cnt_inc;
            reg_bytecnt_d = cnt_inc[BW-1:0];
            state_d       = S_RD_STROBE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state so
  // they appear in the same cycle the sequencer occupies the strobe state.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      lat_q         <= '0;
      rdata         <= '0;
      rdata_valid   <= 1'b0;
      rdata_last    <= 1'b0;
      write_data    <= '0;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      reg_addrvalid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      rdata         <= rdata_d;
      rdata_valid   <= (state_d == S_RD_HOLD);
      rdata_last    <= (state_d == S_RD_HOLD) && is_last;
      write_data    <= write_data_d;
      reg_address   <= reg_address_d;
      reg_bytecnt   <= reg_bytecnt_d;
      reg_read      <= (state_d == S_RD_STROBE);
      reg_write     <= (state_d == S_WR_STROBE);
      reg_addrvalid <= (state_d == S_RD_STROBE) || (state_d == S_WR_STROBE);
      busy          <= (state_d != S_IDLE);
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_cw305_reg_initiator.sv
// Scoreboard bench for cw305_reg_initiator: a latency-1 instance for the main
// traffic and a latency-3 instance for capture timing.
module tb_cw305_reg_initiator;
  import cw305_reg_initiator_pkg::*;

  localparam int AW = REG_ADDR_WIDTH;
  localparam int BW = BYTECNT_SIZE_DEFAULT;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] cnt;
    logic [7:0]    data;
    bit            first;
  } bus_exp_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } rd_exp_t;

  logic usb_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 usb_clk = ~usb_clk;

  // Latency-1 instance signals
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [BW:0]   cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [7:0]    wdata;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [7:0]    rdata;
  logic          busy, done;
  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_bytecnt;
  logic [7:0]    write_data, read_data;
  logic          reg_read, reg_write, reg_addrvalid;

  // Latency-3 instance signals
  logic          cmd3_valid, cmd3_ready, cmd3_write;
  logic [AW-1:0] cmd3_addr;
  logic [BW:0]   cmd3_len;
  logic          wdata3_valid, wdata3_ready;
  logic [7:0]    wdata3;
  logic          rdata3_valid, rdata3_ready, rdata3_last;
  logic [7:0]    rdata3;
  logic          busy3, done3;
  logic [AW-1:0] reg_address3;
  logic [BW-1:0] reg_bytecnt3;
  logic [7:0]    write_data3, read_data3;
  logic          reg_read3, reg_write3, reg_addrvalid3;

  cw305_reg_initiator #(.pREAD_LATENCY(1)) u_dut (
    .usb_clk(usb_clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .busy(busy), .done(done),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .write_data(write_data), .read_data(read_data),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid)
  );

  cw305_reg_initiator #(.pREAD_LATENCY(3)) u_dut3 (
    .usb_clk(usb_clk), .reset_n(reset_n),
    .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready), .cmd_write(cmd3_write),
    .cmd_addr(cmd3_addr), .cmd_len(cmd3_len),
    .wdata_valid(wdata3_valid), .wdata_ready(wdata3_ready), .wdata(wdata3),
    .rdata_valid(rdata3_valid), .rdata_ready(rdata3_ready), .rdata(rdata3),
    .rdata_last(rdata3_last), .busy(busy3), .done(done3),
    .reg_address(reg_address3), .reg_bytecnt(reg_bytecnt3),
    .write_data(write_data3), .read_data(read_data3),
    .reg_read(reg_read3), .reg_write(reg_write3), .reg_addrvalid(reg_addrvalid3)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0, done3_cnt = 0, accept_cnt = 0;
  int viol_overlap = 0, viol_addrvalid = 0, viol_rd_in_hold = 0, viol_ready_busy = 0;
  int last_wr_cyc = 0, last_rd3_cyc = 0;
  int rd_idx = 0, stall_idx = -1, stall_left = 0;

  bus_exp_t wr_q[$];
  bus_exp_t rb_q[$];
  rd_exp_t  rd_q[$];
  rd_exp_t  rd3_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge usb_clk) cyc <= cyc + 1;

  // Bus responders: read_data is valid only in the cycle pREAD_LATENCY after
  // a strobe and 0xEE otherwise, so a mistimed capture shows up as 0xEE.
  bit            h_rd [0:3];
  logic [BW-1:0] h_cnt[0:3];
  bit            h3_rd [0:3];
  logic [BW-1:0] h3_cnt[0:3];

  always @(negedge usb_clk) begin
    for (int i = 3; i > 0; i--) begin
      h_rd[i]   = h_rd[i-1];
      h_cnt[i]  = h_cnt[i-1];
      h3_rd[i]  = h3_rd[i-1];
      h3_cnt[i] = h3_cnt[i-1];
    end
    h_rd[0]   = reg_read;
    h_cnt[0]  = reg_bytecnt;
    h3_rd[0]  = reg_read3;
    h3_cnt[0] = reg_bytecnt3;
    read_data  = h_rd[1]  ? 8'(8'hA0 + 8'(h_cnt[1]))  : 8'hEE;
    read_data3 = h3_rd[3] ? 8'(8'hA0 + 8'(h3_cnt[3])) : 8'hEE;
  end

  // Read-stream consumer with an optional stall on one byte index.
  initial begin
    rdata_ready = 1'b1;
    forever begin
      @(posedge usb_clk);
      #1;
      if (rdata_valid && rd_idx == stall_idx && stall_left > 0) begin
        rdata_ready = 1'b0;
        stall_left--;
      end else begin
        rdata_ready = 1'b1;
      end
    end
  end

  // Monitors and scoreboard comparisons, sampled mid-cycle.
  always @(negedge usb_clk) begin : mon
    bus_exp_t e;
    rd_exp_t  r;
    if (reset_n) begin
      if (done) done_cnt++;
      if (done3) done3_cnt++;
      if (cmd_valid && cmd_ready) accept_cnt++;
      if (cmd_ready && busy) viol_ready_busy++;
      if (reg_read && reg_write) viol_overlap++;
      if (reg_addrvalid != (reg_read || reg_write)) viol_addrvalid++;
      if (rdata_valid && reg_read) viol_rd_in_hold++;

      if (reg_write) begin
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", reg_address, e.addr);
          check("wr_bytecnt", reg_bytecnt, e.cnt);
          check("wr_data", write_data, e.data);
          if (!e.first) check("wr_spacing", cyc - last_wr_cyc, 2);
          last_wr_cyc = cyc;
        end
      end

      if (reg_read) begin
        if (rb_q.size() == 0) check("rd_strobe_unexpected", 1, 0);
        else begin
          e = rb_q.pop_front();
          check("rd_addr", reg_address, e.addr);
          check("rd_bytecnt", reg_bytecnt, e.cnt);
        end
      end

      if (rdata_valid) begin
        if (rd_q.size() == 0) check("rdata_unexpected", 1, 0);
        else begin
          check("rdata", rdata, rd_q[0].data);
          check("rdata_last", rdata_last, rd_q[0].last);
          if (rdata_ready) begin
            r = rd_q.pop_front();
            rd_idx = rdata_last ? 0 : rd_idx + 1;
          end
        end
      end

      if (reg_read3) last_rd3_cyc = cyc;
      if (rdata3_valid) begin
        check("lat3_cycles", cyc - last_rd3_cyc, 4);
        if (rd3_q.size() == 0) check("rdata3_unexpected", 1, 0);
        else begin
          r = rd3_q.pop_front();
          check("rdata3", rdata3, r.data);
          check("rdata3_last", rdata3_last, r.last);
        end
      end
    end
  end

  task automatic wait_cmd_ready(input string tag);
    int n = 0;
    do begin @(negedge usb_clk); n++; end while (!cmd_ready && n < 500);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [BW:0] l);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    wait_cmd_ready("send");
    @(posedge usb_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_wbyte(input logic [7:0] b);
    int n = 0;
    wdata       = b;
    wdata_valid = 1'b1;
    do begin @(negedge usb_clk); n++; end while (!wdata_ready && n < 50);
    check("wdata_ready", wdata_ready, 1);
    @(posedge usb_clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge usb_clk); n++; end while (busy && n < 5000);
    check({tag, "_idle"}, busy, 0);
    @(posedge usb_clk);
    #1;
  endtask

  task automatic push_read(input logic [AW-1:0] a, input int l);
    for (int i = 0; i < l; i++) begin
      rb_q.push_back('{addr: a, cnt: BW'(i), data: 8'h00, first: (i == 0)});
      rd_q.push_back('{data: 8'(8'hA0 + i), last: (i == l - 1)});
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int l);
    push_read(a, l);
    send_cmd(CMD_READ, a, (BW+1)'(l));
    wait_idle("rd");
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int l,
                          input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
    for (int i = 0; i < l; i++) begin
      b = 8'(base + step * i);
      wr_q.push_back('{addr: a, cnt: BW'(i), data: b, first: (i == 0)});
    end
    send_cmd(CMD_WRITE, a, (BW+1)'(l));
    for (int i = 0; i < l; i++) begin
      b = 8'(base + step * i);
      send_wbyte(b);
    end
    wdata_valid = 1'b0;
    wait_idle("wr");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    int n;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    cmd3_valid = 1'b0; cmd3_write = 1'b0; cmd3_addr = '0; cmd3_len = '0;
    wdata3_valid = 1'b0; wdata3 = '0; rdata3_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge usb_clk);
    #1;
    check("rst_flags", {busy, done, reg_read, reg_write, reg_addrvalid,
                        rdata_valid, rdata_last, wdata_ready}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_bus", {reg_address, reg_bytecnt, write_data, rdata}, 0);
    check("rst3_flags", {busy3, done3, reg_read3, reg_write3, rdata3_valid}, 0);
    reset_n = 1'b1;
    @(posedge usb_clk);
    #1;

    // Four-byte write burst
    d0 = done_cnt;
    do_write(14'h05, 4, 8'h11, 8'h11);
    check("wr4_done", done_cnt - d0, 1);
    check("wr4_q_empty", wr_q.size(), 0);

    // Sixteen-byte read burst
    d0 = done_cnt;
    do_read(14'h06, 16);
    check("rd16_done", done_cnt - d0, 1);
    check("rd16_q_empty", rd_q.size() + rb_q.size(), 0);

    // Read with a five-cycle stall on byte 2
    stall_idx  = 2;
    stall_left = 5;
    d0 = done_cnt;
    do_read(14'h08, 6);
    check("stall_consumed", stall_left, 0);
    check("stall_done", done_cnt - d0, 1);
    check("stall_q_empty", rd_q.size() + rb_q.size(), 0);
    stall_idx = -1;

    // Zero-length command: done one cycle after accept, no bus activity
    d0 = done_cnt;
    send_cmd(CMD_READ, 14'h03, '0);
    check("len0_done_high", done, 1);
    check("len0_not_busy", busy, 0);
    @(posedge usb_clk);
    #1;
    check("len0_done_low", done, 0);
    check("len0_done_count", done_cnt - d0, 1);

    // Full-length burst: byte index runs 0..127
    d0 = done_cnt;
    do_write(14'h1F, 128, 8'h00, 8'h03);
    check("wr128_done", done_cnt - d0, 1);
    check("wr128_q_empty", wr_q.size(), 0);

    // Command held valid while busy: second accepted only on return to IDLE
    d0 = done_cnt;
    n  = accept_cnt;
    push_read(14'h0B, 2);
    push_read(14'h0C, 1);
    cmd_write = CMD_READ;
    cmd_addr  = 14'h0B;
    cmd_len   = 8'd2;
    cmd_valid = 1'b1;
    wait_cmd_ready("held_a");
    @(posedge usb_clk);
    #1;
    cmd_addr = 14'h0C;
    cmd_len  = 8'd1;
    wait_cmd_ready("held_b");
    check("held_b_with_done", done, 1);
    @(posedge usb_clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle("held");
    check("held_accepts", accept_cnt - n, 2);
    check("held_done", done_cnt - d0, 2);
    check("held_q_empty", rd_q.size() + rb_q.size(), 0);

    // Latency-3 instance: capture exactly three cycles after each strobe
    d0 = done3_cnt;
    for (int i = 0; i < 3; i++) rd3_q.push_back('{data: 8'(8'hA0 + i), last: (i == 2)});
    cmd3_write = CMD_READ;
    cmd3_addr  = 14'h07;
    cmd3_len   = 8'd3;
    cmd3_valid = 1'b1;
    n = 0;
    do begin @(negedge usb_clk); n++; end while (!cmd3_ready && n < 50);
    check("lat3_cmd_ready", cmd3_ready, 1);
    @(posedge usb_clk);
    #1;
    cmd3_valid = 1'b0;
    n = 0;
    do begin @(negedge usb_clk); n++; end while ((busy3 || rd3_q.size() != 0) && n < 200);
    check("lat3_idle", busy3, 0);
    check("lat3_q_empty", rd3_q.size(), 0);
    @(posedge usb_clk);
    #1;
    check("lat3_done", done3_cnt - d0, 1);

    // Reset during the third read-wait cycle
    push_read(14'h09, 4);
    send_cmd(CMD_READ, 14'h09, 8'd4);
    n = 0;
    do begin @(negedge usb_clk); n++; end while (!(reg_read && reg_bytecnt == 7'd2) && n < 100);
    check("rst_mid_strobe_seen", reg_read, 1);
    @(posedge usb_clk);
    #1;
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_mid_flags", {busy, done, reg_read, reg_write, reg_addrvalid,
                            rdata_valid, rdata_last, wdata_ready}, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_bus", {reg_address, reg_bytecnt, write_data, rdata}, 0);
    rd_q.delete();
    rb_q.delete();
    rd_idx = 0;
    repeat (2) @(posedge usb_clk);
    #1;
    check("rst_mid_done_low", done, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge usb_clk);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_idle", busy, 0);
    d0 = done_cnt;
    do_write(14'h0A, 2, 8'h5A, 8'h01);
    check("post_rst_wr_done", done_cnt - d0, 1);

    // Protocol invariants over the whole run
    check("inv_rd_wr_overlap", viol_overlap, 0);
    check("inv_addrvalid", viol_addrvalid, 0);
    check("inv_read_during_hold", viol_rd_in_hold, 0);
    check("inv_ready_while_busy", viol_ready_busy, 0);
    check("final_q_empty", wr_q.size() + rb_q.size() + rd_q.size() + rd3_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
